pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Fetch-stage program-counter register and next-PC sequencer for the MIPS pipeline.
- Consumes the 32-bit sign-extended, pre-shifted branch offset produced by the 18-bit extender, plus jump/jr/exception requests.
- Holds PC through instruction-memory wait and pipeline stall.
- Implements the MIPS branch delay slot with a one-entry pending-redirect register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; blocks PC advance.
- imem_ready  in  1  instruction memory has returned the word at pc this cycle.
- br_taken  in  1  branch in decode resolved taken.
- br_offset  in  32  sign-extended byte offset (18-bit field extended, already <<2).
- br_base  in  32  address of the branch + 4, i.e. the delay-slot address.
- jump_en  in  1  J/JAL in decode.
- jump_index  in  26  instr_index field.
- jr_en  in  1  JR/JALR in decode.
- jr_addr  in  32  register target.
- exc_en  in  1  exception flush request.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational.
- fetch_valid  out  1  pc is a valid fetch request.
- redirect_pending  out  1  target captured, waiting for delay-slot fetch to complete.
- misalign  out  1  one-cycle pulse: redirect target[1:0] != 0.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=S_START, pending cleared.
  - fetch_valid=0, redirect_pending=0, misalign=0.
  - Reset overrides every other input, including mid-redirect.
- States:
  - S_START: fetch_valid=0; moves unconditionally to S_RUN next cycle.
  - S_RUN: fetch_valid=1, no pending redirect.
  - S_PEND: fetch_valid=1, pending target held.
- Advance condition: adv = fetch_valid & imem_ready & ~stall.
- Redirect request: req = jr_en | jump_en | br_taken. Target priority is jr > jump > branch:
  - jr: jr_addr.
  - jump: {br_base[31:28], jump_index, 2'b00}.
  - branch: br_base + br_offset, mod 2^32; wrap-around is allowed, with no overflow flag.
- Misaligned target: if req and target[1:0] != 0, misalign=1 for the following cycle only and the request is discarded (no state change from it).
- S_RUN:
  - adv & ~req: pc <= pc+4.
  - adv & req: the delay slot completes this cycle, so pc <= target; stay in S_RUN.
  - ~adv & req: pend_target <= target, go to S_PEND; pc held.
  - ~adv & ~req: hold.
- S_PEND:
  - adv: pc <= pend_target, go to S_RUN.
  - Otherwise hold.
  - Any req in S_PEND is ignored; only one redirect per delay slot.
- Exception (exc_en=1, not in reset):
  - pc <= EXC_VECTOR, pending cleared, state <= S_RUN.
  - Takes effect regardless of stall, imem_ready or req, and beats any pending redirect.
- Stall and imem_ready=0 are equivalent for pc. stall never drops a pending target.
- pc+4 at 32'hFFFF_FFFC wraps to 0.
- Latency: a new pc is visible one cycle after the advancing edge; pc_plus4 tracks pc combinationally.

Decomposition:
- Package pc_pkg holds:
  - state encoding (S_START, S_RUN, S_PEND);
  - default RESET_PC and EXC_VECTOR constants;
  - the redirect-kind enumeration (NONE, BR, J, JR).
- One combinational sub-module, pc_target_sel: computes target and target_valid from br/jump/jr inputs with the stated priority and misalign check.
- The sequencer FSM and registers stay in pc_next_unit.

Test Plan:
- Reset release: rst 1->0 with imem_ready=1, no stall:
  - pc=0, fetch_valid=0 for one cycle;
  - then pc=0 valid;
  - then pc advances 4, 8, 12.
- Branch with same-cycle advance: pc=0x100 (delay slot), br_base=0x100, br_offset=32'hFFFF_FFF0, br_taken with imem_ready=1 -> next pc=0xF0, redirect_pending never set.
- Delay-slot wait: pc=0x200, imem_ready=0, jump_en with jump_index=26'h0000040, br_base=0x200:
  - redirect_pending=1, pc holds 0x200 for 3 wait cycles;
  - imem_ready=1 -> next pc=0x100, pending clears.
- Exception over pending: in S_PEND with stall=1, assert exc_en -> next pc=0x180, redirect_pending=0; the dropped target is never fetched.
- Misaligned jr: jr_en, jr_addr=0x302 -> misalign pulses one cycle, pc continues pc+4.
- Second redirect while pending is ignored; reset asserted in S_PEND -> pc=0, fetch_valid=0, redirect_pending=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings and default vectors for the fetch-stage PC sequencer
package pc_pkg;
    typedef enum logic [1:0] {S_START, S_RUN, S_PEND} pc_state_e;
    typedef enum logic [1:0] {NONE, BR, J, JR} redirect_kind_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;
endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel: picks the redirect target (jr > jump > branch) and flags misaligned targets
import pc_pkg::*;
module pc_target_sel (
    input  logic           br_taken,
    input  logic [31:0]    br_offset,
    input  logic [31:0]    br_base,
    input  logic           jump_en,
    input  logic [25:0]    jump_index,
    input  logic           jr_en,
    input  logic [31:0]    jr_addr,
    output redirect_kind_e kind,
    output logic [31:0]    target,
    output logic           target_valid,
    output logic           target_misalign
);
    always_comb begin
        kind = jr_en ? JR : jump_en ? J : br_taken ? BR : NONE;
        target = jr_en ? jr_addr : jump_en ? {br_base[31:28], jump_index, 2'b00} : br_base + br_offset;
        target_valid = (kind != NONE) && (target[1:0] == 2'b00);
        target_misalign = (kind != NONE) && (target[1:0] != 2'b00);
    end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch PC register with delay-slot redirect sequencing and exception flush
import pc_pkg::*;
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic [31:0] br_base,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    input  logic        exc_en,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic        misalign
);
    pc_state_e      state, state_d;
    redirect_kind_e kind;
    logic [31:0]    pend_target, pend_d, pc_d, target;
    logic           target_valid, target_misalign, mis_d, adv;

    pc_target_sel u_sel (
        .br_taken(br_taken),
        .br_offset(br_offset),
        .br_base(br_base),
        .jump_en(jump_en),
        .jump_index(jump_index),
        .jr_en(jr_en),
        .jr_addr(jr_addr),
        .kind(kind),
        .target(target),
        .target_valid(target_valid),
        .target_misalign(target_misalign)
    );

    assign pc_plus4 = pc + 32'd4;
    assign fetch_valid = state != S_START;
    assign redirect_pending = state == S_PEND;
    assign adv = fetch_valid & imem_ready & ~stall;

    always_comb begin
        state_d = state;
        pc_d = pc;
        pend_d = pend_target;
        mis_d = 1'b0;
        if (exc_en) begin
            state_d = S_RUN;
            pc_d = EXC_VECTOR;
            pend_d = '0;
        end else begin
            case (state)
                S_START: state_d = S_RUN;
                S_RUN: begin
                    // the delay slot finishing this cycle lets the redirect bypass the pending register
                    mis_d = target_misalign;
                    if (adv) pc_d = target_valid ? target : pc_plus4;
                    else if (target_valid) begin
                        pend_d = target;
                        state_d = S_PEND;
                    end
                end
                S_PEND: if (adv) begin
                    pc_d = pend_target;
                    state_d = S_RUN;
                end
                default: state_d = S_START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_START;
            pc <= RESET_PC;
            pend_target <= '0;
            misalign <= 1'b0;
        end else begin
            state <= state_d;
            pc <= pc_d;
            pend_target <= pend_d;
            misalign <= mis_d;
        end
    end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed stimulus checked against a cycle model and literal expectations
module tb_pc_next_unit;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, imem_ready = 1'b1;
    logic        br_taken = 1'b0, jump_en = 1'b0, jr_en = 1'b0, exc_en = 1'b0;
    logic [31:0] br_offset = '0, br_base = '0, jr_addr = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, redirect_pending, misalign;
    int          checks = 0, failures = 0;
    logic        chk_on = 1'b0;

    logic [31:0] m_pc, m_tgt, m_t;
    logic        m_valid, m_pend, m_mis, m_rq, m_ok, m_adv;

    pc_next_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
        .br_taken(br_taken), .br_offset(br_offset), .br_base(br_base),
        .jump_en(jump_en), .jump_index(jump_index), .jr_en(jr_en), .jr_addr(jr_addr),
        .exc_en(exc_en), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .redirect_pending(redirect_pending), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // model: "started" flag, "has pending target" flag, plain arithmetic for targets
    always @(posedge clk) begin
        m_rq = jr_en | jump_en | br_taken;
        m_t = jr_en ? jr_addr : jump_en ? {br_base[31:28], jump_index, 2'b00} : br_base + br_offset;
        m_ok = m_rq && (m_t[1:0] == 2'b00);
        m_adv = m_valid && imem_ready && !stall;
        m_mis = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
        end else if (exc_en) begin
            m_pc = 32'h180; m_valid = 1'b1; m_pend = 1'b0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (m_pend) begin
            if (m_adv) begin m_pc = m_tgt; m_pend = 1'b0; end
        end else begin
            m_mis = m_rq && !m_ok;
            if (m_adv) m_pc = m_ok ? m_t : m_pc + 32'd4;
            else if (m_ok) begin m_pend = 1'b1; m_tgt = m_t; end
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("model_pc", pc, m_pc);
        chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("model_fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
        chk("model_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
        chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(); chk_on = 1'b1; cyc();
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
        cyc();
        chk("start_pc", pc, 32'h0);
        chk("start_fv", {31'd0, fetch_valid}, 32'd1);
        cyc(); chk("seq_4", pc, 32'h4);
        cyc(); chk("seq_8", pc, 32'h8);
        cyc(); chk("seq_c", pc, 32'hC);
        jr_en = 1'b1; jr_addr = 32'h100; cyc(); jr_en = 1'b0;
        chk("jr_100", pc, 32'h100);
        br_base = 32'h100; br_offset = 32'hFFFF_FFF0; br_taken = 1'b1;
        cyc(); br_taken = 1'b0;
        chk("br_back", pc, 32'hF0);
        chk("br_nopend", {31'd0, redirect_pending}, 32'd0);
        jr_en = 1'b1; jr_addr = 32'h200; cyc(); jr_en = 1'b0;
        imem_ready = 1'b0; jump_en = 1'b1; jump_index = 26'h40; br_base = 32'h200;
        cyc(); jump_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_pc", pc, 32'h200);
            chk("wait_pend", {31'd0, redirect_pending}, 32'd1);
            if (i < 2) cyc();
        end
        imem_ready = 1'b1; cyc();
        chk("jump_pc", pc, 32'h100);
        chk("jump_pend_clr", {31'd0, redirect_pending}, 32'd0);
        stall = 1'b1; br_taken = 1'b1; br_base = 32'h100; br_offset = 32'h40;
        cyc(); br_taken = 1'b0;
        chk("exc_prepend", {31'd0, redirect_pending}, 32'd1);
        exc_en = 1'b1; cyc(); exc_en = 1'b0; stall = 1'b0;
        chk("exc_pc", pc, 32'h180);
        chk("exc_pend", {31'd0, redirect_pending}, 32'd0);
        cyc(); chk("exc_seq", pc, 32'h184);
        cyc(); chk("exc_seq2", pc, 32'h188);
        jr_en = 1'b1; jr_addr = 32'h302; cyc(); jr_en = 1'b0;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_pc", pc, 32'h18C);
        cyc();
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        chk("mis_pc2", pc, 32'h190);
        imem_ready = 1'b0; jr_en = 1'b1; jr_addr = 32'h400; cyc();
        jr_addr = 32'h500; cyc(); jr_en = 1'b0;
        chk("second_pend", {31'd0, redirect_pending}, 32'd1);
        imem_ready = 1'b1; cyc();
        chk("second_ignored", pc, 32'h400);
        imem_ready = 1'b0; jr_en = 1'b1; jr_addr = 32'h600; cyc(); jr_en = 1'b0;
        chk("pend_before_rst", {31'd0, redirect_pending}, 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0; imem_ready = 1'b1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("midrst_pend", {31'd0, redirect_pending}, 32'd0);
        cyc();
        jr_en = 1'b1; jr_addr = 32'hFFFF_FFFC; cyc(); jr_en = 1'b0;
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_plus4", pc_plus4, 32'h0);
        cyc(); chk("wrap_pc", pc, 32'h0);
        br_taken = 1'b1; br_base = 32'h4; br_offset = 32'hFFFF_FFF8; cyc(); br_taken = 1'b0;
        chk("br_wrap", pc, 32'hFFFF_FFFC);
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
